puf2usrp: RTL and testbench
===========================

Name: puf2usrp

Overview:
- TX-direction counterpart of usrp2puf: takes complex I/Q samples produced by the PUF/key datapath and delivers them toward the USRP radio as framed AXI-stream packets.
- Per-component gain: arithmetic left shift with saturation.
- Buffers samples in a FIFO and emits fixed-length packets with out_tlast, plus an idle gap between packets.
- Sits between the PUF processing chain and the USRP TX stream, using the same {I,Q} packing as the RX side.

Parameters:
- DATA_WIDTH, 16, bits per I or Q component.
- FIFO_DEPTH, 64, sample FIFO entries; power of 2, at least PKT_LEN.
- PKT_LEN, 32, samples per output packet; 1 ≤ PKT_LEN ≤ FIFO_DEPTH.
- GAP_CYCLES, 4, forced out_tvalid=0 cycles after each packet; may be 0.
- SHIFT, 0, left-shift gain applied to I and Q, 0..DATA_WIDTH-1.

Ports:
- clk, input, 1, sole clock.
- reset, input, 1, asynchronous active-low reset.
- in_tdata, input, 2*DATA_WIDTH, {I[2W-1:W], Q[W-1:0]}, signed two's complement.
- in_tvalid, input, 1, upstream sample valid.
- in_tlast, input, 1, end of burst; forces a short-packet flush.
- in_tready, output, 1, space available in the FIFO.
- out_tdata, output, 2*DATA_WIDTH, {I,Q} toward the USRP.
- out_tvalid, output, 1, output beat valid.
- out_tlast, output, 1, last beat of the packet.
- out_tready, input, 1, downstream ready.
- sat_flag, output, 1, sticky: some component saturated since reset.
- pkt_count, output, 16, packets completed; wraps 0xFFFF→0.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
- Values while reset=0: out_tvalid=0, out_tlast=0, out_tdata=0, in_tready=0, sat_flag=0, pkt_count=0, FIFO count=0, last_pending=0, FSM=IDLE.
- Reset mid-packet: the packet is aborted with no tlast, and all stored samples are discarded.
- Input:
  - in_tready = (count < FIFO_DEPTH), from the registered count.
  - A push occurs on in_tvalid & in_tready.
- Gain: each component is computed as x<<SHIFT at full width, then saturated to [-2^(W-1), 2^(W-1)-1].
  - Any clipped component sets sat_flag on the accepting edge.
  - The scaled value and in_tlast are stored together in the FIFO.
- FIFO:
  - First-word-fall-through; head is read combinationally.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - last_pending counts stored entries whose last flag is set: +1 on push with last, -1 on pop with last.
- FSM states IDLE, SEND, GAP:
  - IDLE: out_tvalid=0. Go to SEND when registered count ≥ PKT_LEN or last_pending > 0; clear beat counter.
  - SEND:
    - out_tvalid=1; out_tdata = FIFO head.
    - out_tlast = (beat == PKT_LEN-1) | head.last.
    - Each out_tvalid & out_tready pops the FIFO and increments beat.
    - On a handshake with out_tlast: pkt_count+1; go to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: out_tvalid=0 for exactly GAP_CYCLES cycles, then IDLE.
- Packet completeness: SEND is entered only when enough data for the whole packet is stored, so the FIFO never empties mid-packet.
- Stall: while out_tready=0 in SEND, out_tdata and out_tlast hold stable and no pop occurs.
- Data gating: out_tdata is forced to 0 whenever out_tvalid=0.
- Latency:
  - The accepted input beat that makes count reach PKT_LEN updates count at edge k.
  - FSM enters SEND at edge k+1, so out_tvalid is high after edge k+1 (2 cycles minimum).
- Boundary cases:
  - in_tlast on the PKT_LEN-th beat gives a single tlast; no extra empty packet.
  - in_tlast with 1 stored sample gives a 1-beat packet with tlast.
  - Full FIFO: in_tready=0 until a pop lowers count. Data is never dropped or overwritten.

Test Plan:
- Defaults, 32 samples I=n, Q=-n (n=0..31), out_tready=1 → one packet of 32 beats, tlast on beat 31, data equal to input, pkt_count=1, out_tvalid low for exactly 4 cycles after.
- SHIFT=2; inputs I=0x1000, Q=0xE000, then I=0x3000 → outputs 0x4000/0x8000, then I=0x7FFF; sat_flag=1 after the third sample, stays 1.
- 5 samples with in_tlast on the 5th → 5-beat packet, tlast on beat 4, last_pending returns to 0, no further output.
- out_tready=0 with 70 samples offered → in_tready drops after 64 accepted; out_tdata/out_tlast stable during the stall. Then out_tready=1 → all 70 samples emerge in order across 3 packets (32, 32, and 6 if in_tlast is on the 70th).
- reset pulsed low at beat 10 of a packet → outputs 0 immediately. After release, a new 32-sample input gives a clean packet starting from the new data.
- PKT_LEN=4, GAP_CYCLES=0, continuous input → tlast every 4th beat, out_tvalid continuously 1 except one IDLE cycle per packet.

Source files
------------

// File: rtl/puf2usrp.sv
// PUF/key datapath to USRP TX stream: per-component shift gain with saturation,
// sample FIFO, and fixed-length AXI-stream packets separated by an idle gap.
//
// state | meaning
// IDLE  | waiting for a full packet or a stored burst end
// SEND  | streaming FIFO head, one pop per handshake
// GAP   | forced out_tvalid=0 for GAP_CYCLES cycles
module puf2usrp #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int PKT_LEN    = 32,
  parameter int GAP_CYCLES = 4,
  parameter int SHIFT      = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2*DATA_WIDTH-1:0] in_tdata,
  input  logic                    in_tvalid,
  input  logic                    in_tlast,
  output logic                    in_tready,
  output logic [2*DATA_WIDTH-1:0] out_tdata,
  output logic                    out_tvalid,
  output logic                    out_tlast,
  input  logic                    out_tready,
  output logic                    sat_flag,
  output logic [15:0]             pkt_count
);

  localparam int W  = DATA_WIDTH;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PKT_C     = CW'(PKT_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);
  localparam logic [AW-1:0] PTR_MAX   = AW'(FIFO_DEPTH - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  // returns {clipped, value}; clipping means the upper W+1 bits disagree in sign
  function automatic logic [W:0] gain(input logic [W-1:0] x);
    logic [2*W-1:0] wide;
    wide = {{W{x[W-1]}}, x} << SHIFT;
    if (wide[2*W-1:W-1] != {(W+1){wide[2*W-1]}})
      return {1'b1, wide[2*W-1], {(W-1){~wide[2*W-1]}}};
    return {1'b0, wide[W-1:0]};
  endfunction

  logic [2*W:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt, last_pend;
  logic [CW-1:0] beat, beat_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic          rdy_q, pkt_done, push, pop;
  logic [W:0]    gi, gq;
  logic [2*W:0]  head;
  state_t        state, state_nxt;

  assign gi        = gain(in_tdata[2*W-1:W]);
  assign gq        = gain(in_tdata[W-1:0]);
  assign head      = mem[rd_ptr];
  assign in_tready = rdy_q;
  assign push      = in_tvalid & rdy_q;
  assign pop       = out_tvalid & out_tready;
  assign out_tdata = out_tvalid ? head[2*W-1:0] : '0;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (!push && pop)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {in_tlast, gi[W-1:0], gq[W-1:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_pend <= '0;
      rdy_q     <= 1'b0;
      sat_flag  <= 1'b0;
      pkt_count <= '0;
    end else begin
      count <= count_nxt;
      rdy_q <= (count_nxt < DEPTH_C);
      if (push)
        wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + AW'(1);
      if ((push && in_tlast) && !(pop && head[2*W]))
        last_pend <= last_pend + CW'(1);
      else if (!(push && in_tlast) && (pop && head[2*W]))
        last_pend <= last_pend - CW'(1);
      if (push && (gi[W] || gq[W]))
        sat_flag <= 1'b1;
      if (pkt_done)
        pkt_count <= pkt_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      beat    <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      beat    <= beat_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    gap_nxt    = gap_cnt;
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
    pkt_done   = 1'b0;
    case (state)
      IDLE: begin
        beat_nxt = '0;
        if (count >= PKT_C || last_pend != '0)
          state_nxt = SEND;
      end
      SEND: begin
        out_tvalid = 1'b1;
        out_tlast  = (beat == LAST_BEAT) | head[2*W];
        if (out_tready) begin
          beat_nxt = beat + CW'(1);
          if (out_tlast) begin
            pkt_done = 1'b1;
            if (GAP_CYCLES > 0) begin
              state_nxt = GAP;
              gap_nxt   = GAP_LOAD;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0)
          state_nxt = IDLE;
        else
          gap_nxt = gap_cnt - GW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_puf2usrp.sv
// Directed bench for puf2usrp: default instance for framing/stall/reset,
// a SHIFT=2 instance for saturation, and a PKT_LEN=4/GAP=0 instance for back-to-back packets.
module tb_puf2usrp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_tlast, out_tready, v_a, v_b, v_c;
  logic [31:0] in_tdata;
  logic        rdy_a, ov_a, ol_a, sat_a;
  logic        rdy_b, ov_b, ol_b, sat_b;
  logic        rdy_c, ov_c, ol_c, sat_c;
  logic [31:0] od_a, od_b, od_c;
  logic [15:0] pc_a, pc_b, pc_c;

  puf2usrp u_a (
    .clk(clk), .reset(reset), .in_tdata(in_tdata), .in_tvalid(v_a), .in_tlast(in_tlast),
    .in_tready(rdy_a), .out_tdata(od_a), .out_tvalid(ov_a), .out_tlast(ol_a),
    .out_tready(out_tready), .sat_flag(sat_a), .pkt_count(pc_a));

  puf2usrp #(.SHIFT(2)) u_b (
    .clk(clk), .reset(reset), .in_tdata(in_tdata), .in_tvalid(v_b), .in_tlast(in_tlast),
    .in_tready(rdy_b), .out_tdata(od_b), .out_tvalid(ov_b), .out_tlast(ol_b),
    .out_tready(out_tready), .sat_flag(sat_b), .pkt_count(pc_b));

  puf2usrp #(.PKT_LEN(4), .GAP_CYCLES(0)) u_c (
    .clk(clk), .reset(reset), .in_tdata(in_tdata), .in_tvalid(v_c), .in_tlast(in_tlast),
    .in_tready(rdy_c), .out_tdata(od_c), .out_tvalid(ov_c), .out_tlast(ol_c),
    .out_tready(out_tready), .sat_flag(sat_c), .pkt_count(pc_c));

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // output beats are captured half a cycle before the handshake edge
  int unsigned cyc = 0;
  logic [31:0] qa_d[$], qb_d[$], qc_d[$];
  bit          qa_l[$], qb_l[$], qc_l[$];
  int unsigned qa_t[$], qc_t[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ov_a && out_tready) begin
      qa_d.push_back(od_a); qa_l.push_back(ol_a); qa_t.push_back(cyc);
    end
    if (ov_b && out_tready) begin
      qb_d.push_back(od_b); qb_l.push_back(ol_b);
    end
    if (ov_c && out_tready) begin
      qc_d.push_back(od_c); qc_l.push_back(ol_c); qc_t.push_back(cyc);
    end
  end

  function automatic logic [31:0] mk(input int i, input int q);
    logic [31:0] a, b;
    a = i;
    b = q;
    return {a[15:0], b[15:0]};
  endfunction

  function automatic logic get_rdy(input int which);
    case (which)
      0: return rdy_a;
      1: return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  function automatic logic [15:0] get_pc(input int which);
    case (which)
      0: return pc_a;
      1: return pc_b;
      default: return pc_c;
    endcase
  endfunction

  task automatic set_v(input int which, input logic v);
    case (which)
      0: v_a = v;
      1: v_b = v;
      default: v_c = v;
    endcase
  endtask

  task automatic idle();
    v_a = 1'b0; v_b = 1'b0; v_c = 1'b0; in_tlast = 1'b0;
  endtask

  // returns at #1 after the edge that accepted the beat; valid is left high
  task automatic send(input int which, input logic [31:0] d, input logic last);
    logic r;
    in_tdata = d;
    in_tlast = last;
    set_v(which, 1'b1);
    for (int i = 0; i < 300; i++) begin
      r = get_rdy(which);
      @(posedge clk); #1;
      if (r) return;
    end
    check("send_timeout", 0, 1);
  endtask

  task automatic wait_pc(input int which, input logic [15:0] target, input string tag);
    for (int i = 0; i < 600; i++) begin
      if (get_pc(which) == target) return;
      @(posedge clk); #1;
    end
    check(tag, get_pc(which), target);
  endtask

  task automatic clear_q();
    qa_d.delete(); qa_l.delete(); qa_t.delete();
    qb_d.delete(); qb_l.delete();
    qc_d.delete(); qc_l.delete(); qc_t.delete();
  endtask

  task automatic quiet_a(input int cycles, input string tag);
    int highs;
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ov_a) highs++;
    end
    check(tag, highs, 0);
  endtask

  function automatic logic [31:0] s4(input int i);
    return mk(i * 3, 1000 - i);
  endfunction

  initial begin
    reset = 1'b0; in_tdata = '0; in_tlast = 1'b0; out_tready = 1'b1;
    v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", ov_a, 0);
    check("rst_tlast", ol_a, 0);
    check("rst_tdata", od_a, 0);
    check("rst_tready", rdy_a, 0);
    check("rst_sat", sat_a, 0);
    check("rst_pkt_count", pc_a, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", rdy_a, 1);

    // 32 samples I=n, Q=-n
    clear_q();
    for (int n = 0; n < 32; n++) send(0, mk(n, -n), 1'b0);
    idle();
    check("lat_edge_k", ov_a, 0);
    @(posedge clk); #1;
    check("lat_edge_k1", ov_a, 1);
    wait_pc(0, 16'd1, "t1_timeout");
    check("t1_pkt_count", pc_a, 1);
    check("t1_beats", qa_d.size(), 32);
    for (int n = 0; n < 32 && n < qa_d.size(); n++) begin
      check("t1_data", qa_d[n], mk(n, -n));
      check("t1_last", qa_l[n], (n == 31));
    end
    quiet_a(8, "t1_idle_after");

    // 5-sample burst ending in in_tlast
    clear_q();
    for (int n = 0; n < 5; n++) send(0, mk(256 + n, n), (n == 4));
    idle();
    wait_pc(0, 16'd2, "t3_timeout");
    check("t3_beats", qa_d.size(), 5);
    for (int n = 0; n < 5 && n < qa_d.size(); n++) begin
      check("t3_data", qa_d[n], mk(256 + n, n));
      check("t3_last", qa_l[n], (n == 4));
    end
    quiet_a(40, "t3_no_extra_pkt");

    // single stored sample with in_tlast
    clear_q();
    send(0, mk(32'h7FFF, 32'h8000), 1'b1);
    idle();
    wait_pc(0, 16'd3, "t1b_timeout");
    check("t1b_beats", qa_d.size(), 1);
    if (qa_d.size() > 0) begin
      check("t1b_data", qa_d[0], 32'h7FFF_8000);
      check("t1b_last", qa_l[0], 1);
    end

    // in_tlast on the PKT_LEN-th beat
    clear_q();
    for (int n = 0; n < 32; n++) send(0, mk(100 + n, 7), (n == 31));
    idle();
    wait_pc(0, 16'd4, "t32_timeout");
    check("t32_beats", qa_d.size(), 32);
    for (int n = 0; n < 32 && n < qa_l.size(); n++) check("t32_last", qa_l[n], (n == 31));
    quiet_a(40, "t32_no_extra_pkt");
    check("t32_pkt_count", pc_a, 4);

    // stall with full FIFO, then drain 70 samples
    clear_q();
    out_tready = 1'b0;
    for (int i = 0; i < 64; i++) send(0, s4(i), 1'b0);
    check("full_tready", rdy_a, 0);
    in_tdata = s4(64);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("stall_tvalid", ov_a, 1);
      check("stall_tdata", od_a, s4(0));
      check("stall_tlast", ol_a, 0);
      check("stall_tready", rdy_a, 0);
    end
    check("stall_pkt_count", pc_a, 4);
    out_tready = 1'b1;
    for (int i = 64; i < 70; i++) send(0, s4(i), (i == 69));
    idle();
    wait_pc(0, 16'd7, "t4_timeout");
    check("t4_beats", qa_d.size(), 70);
    for (int i = 0; i < 70 && i < qa_d.size(); i++) begin
      check("t4_data", qa_d[i], s4(i));
      check("t4_last", qa_l[i], (i == 31 || i == 63 || i == 69));
    end
    if (qa_t.size() == 70) begin
      check("t4_back_to_back", qa_t[1] - qa_t[0], 1);
      check("t4_gap_pkt1", qa_t[32] - qa_t[31], 6);
      check("t4_gap_pkt2", qa_t[64] - qa_t[63], 6);
    end

    // reset at beat 10 of a packet
    clear_q();
    for (int n = 0; n < 32; n++) send(0, mk(32'h3000 + n, n), 1'b0);
    idle();
    for (int i = 0; i < 300; i++) begin
      if (qa_d.size() >= 10) break;
      @(posedge clk); #1;
    end
    check("t5_at_beat10", qa_d.size(), 10);
    check("t5_mid_tvalid", ov_a, 1);
    reset = 1'b0;
    #1;
    check("t5_rst_tvalid", ov_a, 0);
    check("t5_rst_tdata", od_a, 0);
    check("t5_rst_tlast", ol_a, 0);
    check("t5_rst_pkt_count", pc_a, 0);
    check("t5_rst_tready", rdy_a, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    clear_q();
    quiet_a(20, "t5_flushed");
    for (int n = 0; n < 32; n++) send(0, mk(32'h4000 + n, -n - 1), 1'b0);
    idle();
    wait_pc(0, 16'd1, "t5_timeout");
    check("t5_beats", qa_d.size(), 32);
    for (int n = 0; n < 32 && n < qa_d.size(); n++) begin
      check("t5_data", qa_d[n], mk(32'h4000 + n, -n - 1));
      check("t5_last", qa_l[n], (n == 31));
    end
    check("t5_sat_unity_gain", sat_a, 0);

    // SHIFT=2 gain and saturation
    send(1, mk(32'h1000, 0), 1'b0);
    send(1, mk(0, 32'hE000), 1'b0);
    check("sat_clear", sat_b, 0);
    send(1, mk(32'h3000, 0), 1'b0);
    check("sat_set", sat_b, 1);
    send(1, mk(0, 32'hA000), 1'b1);
    idle();
    wait_pc(1, 16'd1, "t2_timeout");
    check("t2_beats", qb_d.size(), 4);
    if (qb_d.size() == 4) begin
      check("t2_gain_i", qb_d[0], 32'h4000_0000);
      check("t2_gain_q_min", qb_d[1], 32'h0000_8000);
      check("t2_clip_pos", qb_d[2], 32'h7FFF_0000);
      check("t2_clip_neg", qb_d[3], 32'h0000_8000);
      check("t2_last", qb_l[3], 1);
      check("t2_not_last", qb_l[2], 0);
    end
    check("sat_sticky", sat_b, 1);

    // PKT_LEN=4, no gap, continuous input
    for (int n = 0; n < 12; n++) send(2, mk(32'h5000 + n, n), 1'b0);
    idle();
    wait_pc(2, 16'd3, "t6_timeout");
    check("t6_pkt_count", pc_c, 3);
    check("t6_beats", qc_d.size(), 12);
    for (int n = 0; n < 12 && n < qc_d.size(); n++) begin
      check("t6_data", qc_d[n], mk(32'h5000 + n, n));
      check("t6_last", qc_l[n], (n % 4 == 3));
      if (n > 0) check("t6_spacing", qc_t[n] - qc_t[n-1], (n % 4 == 0) ? 2 : 1);
    end
    check("t6_sat", sat_c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vec_cnt);
    $fatal(1, "watchdog");
  end

endmodule
